axi_lite_ar_router: RTL and testbench

- AXI4-Lite read-path demultiplexer, directly downstream of the address decoder.
- Takes one slave-side AR/R channel pair and the decoder's combinational result for the current AR address.
- Forwards each AR to the selected master port through a one-entry register stage, and steers R responses back.
- Completes decode-error reads internally with SLVERR.
- Preserves response order by locking onto one target while reads are outstanding.

---
 rtl/axi_lite_ar_router.sv | 152 +++++++++++++++
 tb/tb_axi_lite_ar_router.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ar_router.sv
// AXI4-Lite read demux: one slave AR/R pair fanned out to NoMstPorts masters.
// Ports: clk_i/rst_i, slv_ar_*/slv_r_* (upstream), dec_* (decoder), mst_* (per-port packed).
module axi_lite_ar_router #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MaxTrans   = 4,
  localparam int unsigned IdxWidth  = $clog2(NoMstPorts)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [AddrWidth-1:0]            slv_ar_addr_i,
  input  logic [2:0]                      slv_ar_prot_i,
  input  logic                            slv_ar_valid_i,
  output logic                            slv_ar_ready_o,
  input  logic [IdxWidth-1:0]             dec_idx_i,
  input  logic                            dec_error_i,
  output logic [DataWidth-1:0]            slv_r_data_o,
  output logic [1:0]                      slv_r_resp_o,
  output logic                            slv_r_valid_o,
  input  logic                            slv_r_ready_i,
  output logic [NoMstPorts*AddrWidth-1:0] mst_ar_addr_o,
  output logic [NoMstPorts*3-1:0]         mst_ar_prot_o,
  output logic [NoMstPorts-1:0]           mst_ar_valid_o,
  input  logic [NoMstPorts-1:0]           mst_ar_ready_i,
  input  logic [NoMstPorts*DataWidth-1:0] mst_r_data_i,
  input  logic [NoMstPorts*2-1:0]         mst_r_resp_i,
  input  logic [NoMstPorts-1:0]           mst_r_valid_i,
  output logic [NoMstPorts-1:0]           mst_r_ready_o
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic                 buf_valid_q, buf_valid_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [2:0]           prot_q, prot_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxWidth-1:0]  sel_q, sel_d;
  logic                 err_q, err_d;

  logic                 tgt_err;
  logic                 cnt_zero;
  logic                 buf_free;
  logic                 ar_hs;
  logic                 r_hs;
  logic                 sel_ar_rdy;
  logic [DataWidth-1:0] sel_r_data;
  logic [1:0]           sel_r_resp;
  logic                 sel_r_valid;

  assign tgt_err = dec_error_i |
    ({1'b0, dec_idx_i} >= (IdxWidth + 1)'(NoMstPorts));
  assign cnt_zero = (cnt_q == '0);

  // Mux of the locked port; written as a compare loop so an
  // out-of-range sel_q (error lock) simply selects nothing.
  always_comb begin
    sel_ar_rdy  = 1'b0;
    sel_r_data  = '0;
    sel_r_resp  = '0;
    sel_r_valid = 1'b0;
    for (int i = 0; i < NoMstPorts; i++) begin
      if (sel_q == IdxWidth'(i)) begin
        sel_ar_rdy  = mst_ar_ready_i[i];
        sel_r_data  = mst_r_data_i[i*DataWidth +: DataWidth];
        sel_r_resp  = mst_r_resp_i[i*2 +: 2];
        sel_r_valid = mst_r_valid_i[i];
      end
    end
  end

  // Buffer can take a new beat if empty or draining this cycle.
  assign buf_free = !buf_valid_q | sel_ar_rdy;

  // Target may only change once nothing is outstanding, which keeps
  // responses in order without per-transaction bookkeeping.
  assign slv_ar_ready_o = (cnt_q < CntW'(MaxTrans)) & buf_free &
    (cnt_zero | ((tgt_err == err_q) & (tgt_err | (dec_idx_i == sel_q))));

  assign ar_hs = slv_ar_valid_i & slv_ar_ready_o;
  assign r_hs  = slv_r_valid_o & slv_r_ready_i;

  always_comb begin
    buf_valid_d = buf_valid_q & !sel_ar_rdy;
    addr_d      = addr_q;
    prot_d      = prot_q;
    sel_d       = sel_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    if (ar_hs && !tgt_err) begin
      buf_valid_d = 1'b1;
      addr_d      = slv_ar_addr_i;
      prot_d      = slv_ar_prot_i;
    end
    if (ar_hs && cnt_zero) begin
      sel_d = dec_idx_i;
      err_d = tgt_err;
    end
    unique case ({ar_hs, r_hs})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      addr_q      <= '0;
      prot_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      addr_q      <= addr_d;
      prot_q      <= prot_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
    end
  end

  assign mst_ar_addr_o = {NoMstPorts{addr_q}};
  assign mst_ar_prot_o = {NoMstPorts{prot_q}};

  always_comb begin
    mst_ar_valid_o = '0;
    mst_r_ready_o  = '0;
    slv_r_valid_o  = 1'b0;
    slv_r_data_o   = '0;
    slv_r_resp_o   = '0;
    for (int i = 0; i < NoMstPorts; i++) begin
      mst_ar_valid_o[i] = buf_valid_q & (sel_q == IdxWidth'(i));
    end
    if (!cnt_zero) begin
      if (err_q) begin
        // Decode error: answer locally with SLVERR.
        slv_r_valid_o = 1'b1;
        slv_r_resp_o  = 2'b10;
      end else begin
        slv_r_valid_o = sel_r_valid;
        slv_r_data_o  = sel_r_data;
        slv_r_resp_o  = sel_r_resp;
        for (int i = 0; i < NoMstPorts; i++) begin
          mst_r_ready_o[i] = slv_r_ready_i & (sel_q == IdxWidth'(i));
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ar_router.sv
// Bench for axi_lite_ar_router: directed scenarios plus randomized traffic
// checked against an in-order transaction scoreboard.
module tb_axi_lite_ar_router;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rst3 = 1'b1;
  logic [31:0]  ar_addr = '0;
  logic [2:0]   ar_prot = '0;
  logic         ar_valid = 1'b0;
  logic         ar_ready;
  logic [1:0]   dec_idx = '0;
  logic         dec_err = 1'b0;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_valid;
  logic         r_ready = 1'b0;
  logic [127:0] m_ar_addr;
  logic [11:0]  m_ar_prot;
  logic [3:0]   m_ar_valid;
  logic [3:0]   m_ar_ready = '0;
  logic [127:0] m_r_data = '0;
  logic [7:0]   m_r_resp = '0;
  logic [3:0]   m_r_valid = '0;
  logic [3:0]   m_r_ready;

  logic         u3_ar_ready;
  logic [31:0]  u3_r_data;
  logic [1:0]   u3_r_resp;
  logic         u3_r_valid;
  logic [95:0]  u3_m_ar_addr;
  logic [8:0]   u3_m_ar_prot;
  logic [2:0]   u3_m_ar_valid;
  logic [2:0]   u3_m_r_ready;
  logic [2:0]   z3_ready = '0;
  logic [95:0]  z3_data = '0;
  logic [5:0]   z3_resp = '0;
  logic [2:0]   z3_valid = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_lite_ar_router dut (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_addr_i(ar_addr), .slv_ar_prot_i(ar_prot),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready),
    .dec_idx_i(dec_idx), .dec_error_i(dec_err),
    .slv_r_data_o(r_data), .slv_r_resp_o(r_resp),
    .slv_r_valid_o(r_valid), .slv_r_ready_i(r_ready),
    .mst_ar_addr_o(m_ar_addr), .mst_ar_prot_o(m_ar_prot),
    .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(m_ar_ready),
    .mst_r_data_i(m_r_data), .mst_r_resp_i(m_r_resp),
    .mst_r_valid_i(m_r_valid), .mst_r_ready_o(m_r_ready)
  );

  axi_lite_ar_router #(.NoMstPorts(3)) u3 (
    .clk_i(clk), .rst_i(rst3),
    .slv_ar_addr_i(ar_addr), .slv_ar_prot_i(ar_prot),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(u3_ar_ready),
    .dec_idx_i(dec_idx), .dec_error_i(dec_err),
    .slv_r_data_o(u3_r_data), .slv_r_resp_o(u3_r_resp),
    .slv_r_valid_o(u3_r_valid), .slv_r_ready_i(r_ready),
    .mst_ar_addr_o(u3_m_ar_addr), .mst_ar_prot_o(u3_m_ar_prot),
    .mst_ar_valid_o(u3_m_ar_valid), .mst_ar_ready_i(z3_ready),
    .mst_r_data_i(z3_data), .mst_r_resp_i(z3_resp),
    .mst_r_valid_i(z3_valid), .mst_r_ready_o(u3_m_r_ready)
  );

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ar_ready got %b want 1", ar_ready);
    end
    n_cmp++;
    if (r_valid !== 1'b0 || m_ar_valid !== 4'b0 || m_r_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_valids got r=%b ar=%b rr=%b want 0",
               r_valid, m_ar_valid, m_r_ready);
    end
    n_cmp++;
    if (r_data !== 32'h0 || r_resp !== 2'b00) begin
      n_bad++; $display("FAIL reset_data got %h/%b want 0", r_data, r_resp);
    end
  endtask

  task automatic test_single();
    ar_valid = 1; ar_addr = 32'h1000_0040; ar_prot = 3'b101; dec_idx = 2;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_ready got %b want 1", ar_ready);
    end
    cyc();
    ar_valid = 0;
    #1;
    n_cmp++;
    if (m_ar_valid !== 4'b0100 || m_ar_addr[64 +: 32] !== 32'h1000_0040 ||
        m_ar_prot[6 +: 3] !== 3'b101) begin
      n_bad++;
      $display("FAIL single_ar got v=%b a=%h p=%b want 0100/10000040/101",
               m_ar_valid, m_ar_addr[64 +: 32], m_ar_prot[6 +: 3]);
    end
    m_ar_ready[2] = 1;
    cyc();
    m_ar_ready = '0;
    m_r_valid[2] = 1; m_r_data[64 +: 32] = 32'hDEAD_BEEF;
    m_r_resp[4 +: 2] = 2'b00; r_ready = 1;
    #1;
    n_cmp++;
    if (r_valid !== 1'b1 || r_data !== 32'hDEAD_BEEF || r_resp !== 2'b00 ||
        m_r_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_r got v=%b d=%h r=%b rr=%b want 1/deadbeef/00/0100",
               r_valid, r_data, r_resp, m_r_ready);
    end
    cyc();
    m_r_valid = '0;
    #1;
    n_cmp++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_done got rv=%b ardy=%b want 0/1", r_valid, ar_ready);
    end
    r_ready = 0;
  endtask

  task automatic test_back_to_back();
    m_ar_ready[1] = 1; dec_idx = 1; ar_valid = 1; ar_prot = 3'b010;
    for (int i = 0; i < 5; i++) begin
      ar_addr = 32'h2000_0000 + 32'(i);
      #1;
      n_cmp++;
      if (ar_ready !== (i < 4)) begin
        n_bad++; $display("FAIL b2b_ready[%0d] got %b want %b", i, ar_ready, i < 4);
      end
      if (i > 0) begin
        n_cmp++;
        if (m_ar_valid !== 4'b0010 || m_ar_addr[32 +: 32] !== 32'h2000_0000 + 32'(i - 1)) begin
          n_bad++;
          $display("FAIL b2b_ar[%0d] got %b/%h want 0010/%h", i, m_ar_valid,
                   m_ar_addr[32 +: 32], 32'h2000_0000 + 32'(i - 1));
        end
      end
      cyc();
    end
    m_r_valid[1] = 1; m_r_data[32 +: 32] = 32'h1111_0000; r_ready = 1;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_full got %b want 0", ar_ready);
    end
    cyc();
    m_r_valid = '0;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_reopen got %b want 1", ar_ready);
    end
    cyc();
    ar_valid = 0;
    #1;
    n_cmp++;
    if (m_ar_valid !== 4'b0010 || m_ar_addr[32 +: 32] !== 32'h2000_0004) begin
      n_bad++;
      $display("FAIL b2b_fifth got %b/%h want 0010/20000004",
               m_ar_valid, m_ar_addr[32 +: 32]);
    end
    m_r_valid[1] = 1;
    for (int i = 0; i < 4; i++) cyc();
    m_r_valid = '0; m_ar_ready = '0;
    #1;
    n_cmp++;
    if (r_valid !== 1'b0 || m_ar_valid !== 4'b0) begin
      n_bad++; $display("FAIL b2b_drain got rv=%b ar=%b want 0/0", r_valid, m_ar_valid);
    end
    r_ready = 0;
  endtask

  task automatic test_switch();
    ar_valid = 1; dec_idx = 1; ar_addr = 32'h3000_0000;
    cyc();
    dec_idx = 3; ar_addr = 32'h3000_0300; m_ar_ready[1] = 1;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b0) begin
      n_bad++; $display("FAIL switch_block0 got %b want 0", ar_ready);
    end
    cyc();
    m_ar_ready = '0;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b0) begin
      n_bad++; $display("FAIL switch_block1 got %b want 0", ar_ready);
    end
    m_r_valid[1] = 1; r_ready = 1;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b0) begin
      n_bad++; $display("FAIL switch_nobypass got %b want 0", ar_ready);
    end
    cyc();
    m_r_valid = '0;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL switch_open got %b want 1", ar_ready);
    end
    cyc();
    ar_valid = 0;
    #1;
    n_cmp++;
    if (m_ar_valid !== 4'b1000 || m_ar_addr[96 +: 32] !== 32'h3000_0300) begin
      n_bad++;
      $display("FAIL switch_ar got %b/%h want 1000/30000300",
               m_ar_valid, m_ar_addr[96 +: 32]);
    end
    m_ar_ready[3] = 1;
    cyc();
    m_ar_ready = '0; m_r_valid[3] = 1;
    cyc();
    m_r_valid = '0;
    #1;
    n_cmp++;
    if (r_valid !== 1'b0) begin
      n_bad++; $display("FAIL switch_done got %b want 0", r_valid);
    end
    r_ready = 0;
  endtask

  task automatic test_dec_error();
    ar_valid = 1; dec_err = 1; ar_addr = 32'hF000_0000;
    #1;
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL err_ready got %b want 1", ar_ready);
    end
    cyc();
    ar_valid = 0; dec_err = 0; r_ready = 0;
    #1;
    n_cmp++;
    if (m_ar_valid !== 4'b0 || r_valid !== 1'b1 || r_resp !== 2'b10 ||
        r_data !== 32'h0 || m_r_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL err_resp got ar=%b v=%b r=%b d=%h rr=%b want 0/1/10/0/0",
               m_ar_valid, r_valid, r_resp, r_data, m_r_ready);
    end
    cyc();
    n_cmp++;
    if (r_valid !== 1'b1 || r_resp !== 2'b10) begin
      n_bad++; $display("FAIL err_hold got %b/%b want 1/10", r_valid, r_resp);
    end
    r_ready = 1;
    cyc();
    n_cmp++;
    if (r_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_done got %b want 0", r_valid);
    end
    r_ready = 0;
  endtask

  task automatic test_stray();
    ar_valid = 1; dec_idx = 2; ar_addr = 32'h4000_0000;
    cyc();
    ar_valid = 0; m_ar_ready[2] = 1;
    cyc();
    m_ar_ready = '0;
    m_r_valid[0] = 1; m_r_data[0 +: 32] = 32'hBAD0_BAD0; r_ready = 1;
    #1;
    n_cmp++;
    if (m_r_ready[0] !== 1'b0 || r_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_ignored got rr0=%b rv=%b want 0/0", m_r_ready[0], r_valid);
    end
    cyc();
    m_r_valid[2] = 1; m_r_data[64 +: 32] = 32'h0BAD_F00D; m_r_resp[4 +: 2] = 2'b01;
    #1;
    n_cmp++;
    if (r_valid !== 1'b1 || r_data !== 32'h0BAD_F00D || r_resp !== 2'b01 ||
        m_r_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL stray_route got v=%b d=%h r=%b rr=%b want 1/0badf00d/01/0100",
               r_valid, r_data, r_resp, m_r_ready);
    end
    cyc();
    m_r_valid = '0; r_ready = 0;
  endtask

  task automatic test_out_of_range();
    rst = 1; rst3 = 0;
    cyc();
    ar_valid = 1; dec_idx = 3; ar_addr = 32'h5000_0000;
    #1;
    n_cmp++;
    if (u3_ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL oor_ready got %b want 1", u3_ar_ready);
    end
    cyc();
    ar_valid = 0; r_ready = 0;
    #1;
    n_cmp++;
    if (u3_r_valid !== 1'b1 || u3_r_resp !== 2'b10 || u3_r_data !== 32'h0 ||
        u3_m_ar_valid !== 3'b0 || u3_m_r_ready !== 3'b0) begin
      n_bad++;
      $display("FAIL oor_resp got v=%b r=%b d=%h ar=%b want 1/10/0/000",
               u3_r_valid, u3_r_resp, u3_r_data, u3_m_ar_valid);
    end
    r_ready = 1;
    cyc();
    n_cmp++;
    if (u3_r_valid !== 1'b0) begin
      n_bad++; $display("FAIL oor_done got %b want 0", u3_r_valid);
    end
    r_ready = 0; rst3 = 1; rst = 0;
    cyc();
  endtask

  task automatic test_reset_inflight();
    ar_valid = 1; dec_idx = 0; ar_addr = 32'h6000_0000;
    cyc();
    ar_addr = 32'h6000_0004; m_ar_ready[0] = 1;
    cyc();
    ar_valid = 0; m_ar_ready = '0;
    #1;
    n_cmp++;
    if (m_ar_valid !== 4'b0001 || m_ar_addr[0 +: 32] !== 32'h6000_0004) begin
      n_bad++;
      $display("FAIL rst_pre got %b/%h want 0001/60000004", m_ar_valid, m_ar_addr[31:0]);
    end
    rst = 1;
    cyc();
    rst = 0;
    #1;
    n_cmp++;
    if (m_ar_valid !== 4'b0 || r_valid !== 1'b0 || ar_ready !== 1'b1 ||
        m_r_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_post got ar=%b rv=%b rdy=%b rr=%b want 0/0/1/0",
               m_ar_valid, r_valid, ar_ready, m_r_ready);
    end
    ar_valid = 1; dec_idx = 3; ar_addr = 32'h6000_0300;
    cyc();
    ar_valid = 0;
    #1;
    n_cmp++;
    if (m_ar_valid !== 4'b1000 || m_ar_addr[96 +: 32] !== 32'h6000_0300) begin
      n_bad++;
      $display("FAIL rst_new got %b/%h want 1000/60000300", m_ar_valid, m_ar_addr[96 +: 32]);
    end
    m_ar_ready[3] = 1;
    cyc();
    m_ar_ready = '0; m_r_valid[3] = 1; r_ready = 1;
    cyc();
    m_r_valid = '0; r_ready = 0;
  endtask

  task automatic test_random();
    logic [31:0] arq_addr[$];
    logic [2:0]  arq_prot[$];
    int          arq_port[$];
    logic [31:0] pend_addr[$];
    int          pend_port[$];
    logic [31:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    int outst = 0;
    int lock_idx = 0;
    bit lock_err = 0;
    bit ar_hold = 0;
    bit rv_hold = 0;
    int last_idx = 0;
    bit done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!ar_hold && c < 2500 && $urandom_range(0, 2) != 0) begin
        ar_hold = 1;
        ar_addr = $urandom;
        ar_prot = 3'($urandom_range(0, 7));
        dec_err = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) last_idx = $urandom_range(0, 3);
        dec_idx = 2'(last_idx);
      end
      ar_valid = ar_hold;
      r_ready = ($urandom_range(0, 3) != 0);
      m_ar_ready = 4'($urandom);
      if (!rv_hold) begin
        m_r_valid = '0;
        if (pend_addr.size() > 0 && $urandom_range(0, 1) == 1) begin
          int p;
          p = pend_port[0];
          rv_hold = 1;
          m_r_valid[p] = 1;
          m_r_data[p*32 +: 32] = rdata(pend_addr[0]);
          m_r_resp[p*2 +: 2] = pend_addr[0][3:2];
        end
      end
      @(negedge clk);
      n_cmp++;
      if ($countones(m_ar_valid) > 1) begin
        n_bad++; $display("FAIL rnd_onehot got %b want <=1 bit", m_ar_valid);
      end
      for (int p = 0; p < 4; p++) begin
        if (m_ar_valid[p] && m_ar_ready[p]) begin
          n_cmp++;
          if (arq_addr.size() == 0) begin
            n_bad++; $display("FAIL rnd_ar_unexpected port %0d addr %h", p, m_ar_addr[p*32 +: 32]);
          end else begin
            if (arq_port[0] != p || m_ar_addr[p*32 +: 32] !== arq_addr[0] ||
                m_ar_prot[p*3 +: 3] !== arq_prot[0]) begin
              n_bad++;
              $display("FAIL rnd_ar got port %0d %h/%b want port %0d %h/%b", p,
                       m_ar_addr[p*32 +: 32], m_ar_prot[p*3 +: 3],
                       arq_port[0], arq_addr[0], arq_prot[0]);
            end
            pend_addr.push_back(arq_addr[0]);
            pend_port.push_back(arq_port[0]);
            void'(arq_addr.pop_front());
            void'(arq_prot.pop_front());
            void'(arq_port.pop_front());
          end
        end
      end
      if (rv_hold && m_r_ready[pend_port[0]]) begin
        rv_hold = 0;
        void'(pend_addr.pop_front());
        void'(pend_port.pop_front());
      end
      if (r_valid && r_ready) begin
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_bad++; $display("FAIL rnd_r_unexpected got %h/%b", r_data, r_resp);
        end else begin
          if (r_data !== exp_data[0] || r_resp !== exp_resp[0]) begin
            n_bad++;
            $display("FAIL rnd_r got %h/%b want %h/%b", r_data, r_resp,
                     exp_data[0], exp_resp[0]);
          end
          void'(exp_data.pop_front());
          void'(exp_resp.pop_front());
        end
      end
      if (ar_valid && ar_ready) begin
        n_cmp++;
        if (outst >= 4 || (outst > 0 && (dec_err != lock_err ||
            (!dec_err && int'(dec_idx) != lock_idx)))) begin
          n_bad++;
          $display("FAIL rnd_lock got accept idx %0d err %b want stall (out %0d lock %0d/%b)",
                   dec_idx, dec_err, outst, lock_idx, lock_err);
        end
        if (outst == 0) begin
          lock_idx = int'(dec_idx);
          lock_err = dec_err;
        end
        if (dec_err) begin
          exp_data.push_back(32'h0);
          exp_resp.push_back(2'b10);
        end else begin
          exp_data.push_back(rdata(ar_addr));
          exp_resp.push_back(ar_addr[3:2]);
          arq_addr.push_back(ar_addr);
          arq_prot.push_back(ar_prot);
          arq_port.push_back(int'(dec_idx));
        end
        ar_hold = 0;
        outst++;
      end
      if (r_valid && r_ready) outst--;
      if (c >= 2500 && !ar_hold && outst == 0) done = 1;
    end
    n_cmp++;
    if (!done || exp_data.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_drain got %0d outstanding want 0", exp_data.size());
    end
    @(posedge clk);
    #1;
    ar_valid = 0; r_ready = 0; m_ar_ready = '0; m_r_valid = '0; dec_err = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cyc();
    cyc();
    rst = 0;
    test_reset();
    cyc();
    test_single();
    test_back_to_back();
    test_switch();
    test_dec_error();
    test_stray();
    test_out_of_range();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
